// File: rtl/mem_resp_pkg.sv
// Shared types and widths for the data-memory responder.
package mem_resp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int WORD_W = 32;
  localparam int OFFS_W = 2;

endpackage

// File: rtl/resp_ram.sv
// Word-addressed backing store: asynchronous read, synchronous write, no reset.
module resp_ram
  import mem_resp_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int IDX_W = 6
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [IDX_W-1:0]  i_idx,
  input  logic [WORD_W-1:0] i_wdata,
  output logic [WORD_W-1:0] o_rdata
);

  logic [WORD_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_idx] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_idx];

endmodule

// File: rtl/mem_responder.sv
// Target side of the core's data-memory port: one request at a time,
// LATENCY wait states, then a held response plus a sticky pass-signature flag.
module mem_responder
  import mem_resp_pkg::*;
#(
  parameter int          DEPTH    = 64,
  parameter int          LATENCY  = 2,
  parameter logic [31:0] MON_ADDR = 32'h64,
  parameter logic [31:0] MON_DATA = 32'd7
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [WORD_W-1:0] req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [WORD_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              mon_hit
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [WORD_W-OFFS_W-1:0] DEPTH_WORDS = (WORD_W-OFFS_W)'(DEPTH);
  localparam logic [3:0] CNT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  state_t            r_state;
  logic [3:0]        r_cnt;
  logic              r_we;
  logic [WORD_W-1:0] r_addr;
  logic [WORD_W-1:0] r_wdata;
  logic [WORD_W-1:0] r_rdata;
  logic              r_err;
  logic              r_monHit;

  logic              w_accept;
  logic              w_commit;
  logic              w_cWe;
  logic [WORD_W-1:0] w_cAddr;
  logic [WORD_W-1:0] w_cWdata;
  logic              w_err;
  logic [IDX_W-1:0]  w_idx;
  logic              w_ramWe;
  logic [WORD_W-1:0] w_ramRdata;
  logic              w_monMatch;

  assign w_accept = req_valid && (r_state == IDLE);

  // With zero wait states the access commits on the acceptance edge itself,
  // so the datapath must see the live request instead of the captured copy.
  assign w_commit = (LATENCY == 0) ? w_accept : ((r_state == WAIT) && (r_cnt == 4'd0));
  assign w_cWe    = (LATENCY == 0) ? req_we    : r_we;
  assign w_cAddr  = (LATENCY == 0) ? req_addr  : r_addr;
  assign w_cWdata = (LATENCY == 0) ? req_wdata : r_wdata;

  assign w_err      = (w_cAddr[OFFS_W-1:0] != '0) || (w_cAddr[WORD_W-1:OFFS_W] >= DEPTH_WORDS);
  assign w_idx      = w_cAddr[IDX_W+OFFS_W-1:OFFS_W];
  assign w_ramWe    = w_commit && w_cWe && !w_err;
  assign w_monMatch = (w_cAddr == MON_ADDR) && (w_cWdata == MON_DATA);

  resp_ram #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_ramWe),
    .i_idx   (w_idx),
    .i_wdata (w_cWdata),
    .o_rdata (w_ramRdata)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= IDLE;
      r_cnt    <= 4'd0;
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rdata  <= '0;
      r_err    <= 1'b0;
      r_monHit <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_we    <= req_we;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
            if (LATENCY == 0) begin
              r_state <= RESP;
            end else begin
              r_state <= WAIT;
              r_cnt   <= CNT_INIT;
            end
          end
        end
        WAIT: begin
          if (r_cnt == 4'd0) begin
            r_state <= RESP;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase

      if (w_commit) begin
        r_rdata <= (!w_err && !w_cWe) ? w_ramRdata : '0;
        r_err   <= w_err;
        if (w_ramWe && w_monMatch) begin
          r_monHit <= 1'b1;
        end
      end
    end
  end

  assign req_ready = (r_state == IDLE);
  assign rsp_valid = (r_state == RESP);
  assign rsp_rdata = r_rdata;
  assign rsp_err   = r_err;
  assign mon_hit   = r_monHit;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench: a LATENCY=2 responder for the main tests and a LATENCY=0
// instance for the zero-wait-state timing.
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        reset;

  logic        req_valid, req_we, rsp_ready;
  logic [31:0] req_addr, req_wdata;
  logic        req_ready, rsp_valid, rsp_err, mon_hit;
  logic [31:0] rsp_rdata;

  logic        req_valid0, req_we0, rsp_ready0;
  logic [31:0] req_addr0, req_wdata0;
  logic        req_ready0, rsp_valid0, rsp_err0, mon_hit0;
  logic [31:0] rsp_rdata0;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_responder #(.DEPTH(64), .LATENCY(2)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .mon_hit(mon_hit)
  );

  mem_responder #(.DEPTH(64), .LATENCY(0)) dut0 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid0), .req_ready(req_ready0), .req_we(req_we0),
    .req_addr(req_addr0), .req_wdata(req_wdata0),
    .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready0),
    .rsp_rdata(rsp_rdata0), .rsp_err(rsp_err0), .mon_hit(mon_hit0)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Waits (at negedges) for rsp_valid, checking req_ready stays low meanwhile.
  task automatic waitRspValid(input string tag, output int lat);
    lat = 1;
    while (rsp_valid !== 1'b1 && lat < 20) begin
      checkOutput({tag, "_busy"}, {31'd0, req_ready}, 32'd0);
      @(negedge clk);
      lat++;
    end
    if (rsp_valid !== 1'b1) begin
      checkOutput({tag, "_timeout"}, {31'd0, rsp_valid}, 32'd1);
    end
  endtask

  // One full request on the LATENCY=2 instance with immediate handshake.
  task automatic applyStimulus(input string tag, input logic we, input logic [31:0] addr,
                               input logic [31:0] wdata, output logic [31:0] rdata,
                               output logic err, output int lat);
    @(negedge clk);
    checkOutput({tag, "_ready"}, {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
    @(negedge clk);
    req_valid = 1'b0;
    waitRspValid(tag, lat);
    rdata = rsp_rdata;
    err   = rsp_err;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    checkOutput({tag, "_idle"}, {30'd0, req_ready, rsp_valid}, 32'd2);
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;
    logic [31:0] holdData;
    logic        holdErr;

    reset = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; rsp_ready = 1'b0;
    req_valid0 = 1'b0; req_we0 = 1'b0; req_addr0 = '0; req_wdata0 = '0; rsp_ready0 = 1'b1;
    #2;
    checkOutput("rst_ready", {31'd0, req_ready}, 32'd1);
    checkOutput("rst_valid", {31'd0, rsp_valid}, 32'd0);
    checkOutput("rst_rdata", rsp_rdata, 32'd0);
    checkOutput("rst_err",   {31'd0, rsp_err}, 32'd0);
    checkOutput("rst_mon",   {31'd0, mon_hit}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Store then load at 0x10
    applyStimulus("st10", 1'b1, 32'h10, 32'hDEADBEEF, rd, er, lat);
    checkOutput("st10_lat", lat, 3);
    checkOutput("st10_rdata", rd, 32'd0);
    checkOutput("st10_err", {31'd0, er}, 32'd0);
    applyStimulus("ld10", 1'b0, 32'h10, 32'h0, rd, er, lat);
    checkOutput("ld10_lat", lat, 3);
    checkOutput("ld10_rdata", rd, 32'hDEADBEEF);
    checkOutput("ld10_err", {31'd0, er}, 32'd0);

    // Highest legal word
    applyStimulus("stFC", 1'b1, 32'hFC, 32'hA5A5_0F0F, rd, er, lat);
    checkOutput("stFC_err", {31'd0, er}, 32'd0);
    applyStimulus("ldFC", 1'b0, 32'hFC, 32'h0, rd, er, lat);
    checkOutput("ldFC_rdata", rd, 32'hA5A5_0F0F);

    // Error cases
    applyStimulus("st64", 1'b1, 32'h64, 32'h1234_5678, rd, er, lat);
    applyStimulus("ld100", 1'b0, 32'h100, 32'h0, rd, er, lat);
    checkOutput("ld100_err", {31'd0, er}, 32'd1);
    checkOutput("ld100_rdata", rd, 32'd0);
    applyStimulus("st65", 1'b1, 32'h65, 32'hFFFF_FFFF, rd, er, lat);
    checkOutput("st65_err", {31'd0, er}, 32'd1);
    checkOutput("st65_rdata", rd, 32'd0);
    applyStimulus("ld64", 1'b0, 32'h64, 32'h0, rd, er, lat);
    checkOutput("ld64_rdata", rd, 32'h1234_5678);
    checkOutput("ld64_err", {31'd0, er}, 32'd0);

    // Backpressure on a load response
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10;
    @(negedge clk);
    req_valid = 1'b0;
    waitRspValid("bp", lat);
    holdData = 32'hDEADBEEF;
    holdErr  = 1'b0;
    for (int c = 0; c < 4; c++) begin
      checkOutput($sformatf("bp_valid%0d", c), {31'd0, rsp_valid}, 32'd1);
      checkOutput($sformatf("bp_rdata%0d", c), rsp_rdata, holdData);
      checkOutput($sformatf("bp_err%0d", c), {31'd0, rsp_err}, {31'd0, holdErr});
      if (c == 3) rsp_ready = 1'b1;
      @(negedge clk);
    end
    rsp_ready = 1'b0;
    checkOutput("bp_idle", {30'd0, req_ready, rsp_valid}, 32'd2);

    // Reset during WAIT drops the store
    applyStimulus("st20", 1'b1, 32'h20, 32'h11, rd, er, lat);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'h55;
    @(negedge clk);
    req_valid = 1'b0;
    checkOutput("wait_busy", {31'd0, req_ready}, 32'd0);
    reset = 1'b1;
    #1;
    checkOutput("rstwait_ready", {31'd0, req_ready}, 32'd1);
    checkOutput("rstwait_valid", {31'd0, rsp_valid}, 32'd0);
    #1;
    reset = 1'b0;
    applyStimulus("ld20", 1'b0, 32'h20, 32'h0, rd, er, lat);
    checkOutput("ld20_rdata", rd, 32'h11);

    // Pass monitor
    applyStimulus("mon6", 1'b1, 32'h64, 32'd6, rd, er, lat);
    checkOutput("mon6_hit", {31'd0, mon_hit}, 32'd0);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h64; req_wdata = 32'd7;
    @(negedge clk);
    req_valid = 1'b0;
    checkOutput("mon7_pre", {31'd0, mon_hit}, 32'd0);
    waitRspValid("mon7", lat);
    checkOutput("mon7_hit", {31'd0, mon_hit}, 32'd1);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    applyStimulus("mon0", 1'b1, 32'h64, 32'd0, rd, er, lat);
    checkOutput("mon0_hit", {31'd0, mon_hit}, 32'd1);
    reset = 1'b1;
    #1;
    checkOutput("monrst_hit", {31'd0, mon_hit}, 32'd0);
    #1;
    reset = 1'b0;

    // Zero-latency instance, rsp_ready tied high
    @(negedge clk);
    checkOutput("z_ready0", {31'd0, req_ready0}, 32'd1);
    req_valid0 = 1'b1; req_we0 = 1'b1; req_addr0 = 32'h8; req_wdata0 = 32'hCAFEF00D;
    @(negedge clk);
    checkOutput("z_st_valid", {30'd0, req_ready0, rsp_valid0}, 32'd1);
    checkOutput("z_st_rdata", rsp_rdata0, 32'd0);
    req_we0 = 1'b0;
    @(negedge clk);
    checkOutput("z_idle1", {30'd0, req_ready0, rsp_valid0}, 32'd2);
    @(negedge clk);
    checkOutput("z_ld1_valid", {30'd0, req_ready0, rsp_valid0}, 32'd1);
    checkOutput("z_ld1_rdata", rsp_rdata0, 32'hCAFEF00D);
    @(negedge clk);
    checkOutput("z_idle2", {30'd0, req_ready0, rsp_valid0}, 32'd2);
    @(negedge clk);
    req_valid0 = 1'b0;
    checkOutput("z_ld2_valid", {30'd0, req_ready0, rsp_valid0}, 32'd1);
    checkOutput("z_ld2_err", {31'd0, rsp_err0}, 32'd0);
    @(negedge clk);
    checkOutput("z_idle3", {30'd0, req_ready0, rsp_valid0}, 32'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Target-side data-memory responder for the ARM core's load/store port: the other end of the data memory interface.
- Accepts one word request at a time over a valid/ready request channel and inserts a configurable number of wait states.
- Returns read data or write completion over a valid/ready response channel.
- Used by the upcoming multicycle/handshaked core and by its testbench; includes a sticky monitor flag for the "write 7 to 0x64" pass signature.

Parameters:
- DEPTH, 64, number of 32-bit words; legal byte addresses are 0 .. 4*DEPTH-4.
- LATENCY, 2, wait-state cycles between acceptance and response (0 legal, max 15).
- MON_ADDR, 32'h64, byte address watched by the pass monitor.
- MON_DATA, 32'd7, data value that sets the monitor flag.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  initiator accepts the response.
- rsp_rdata  out  32  load data; 0 for stores and errors.
- rsp_err  out  1  request was out of range or misaligned.
- mon_hit  out  1  sticky: a successful store of MON_DATA to MON_ADDR has occurred.

Behaviour:
- Interface: clock clk; reset reset, asynchronous, active-high.
- FSM states: IDLE, WAIT, RESP.
- req_ready = (state == IDLE), combinational from state only.
- rsp_valid = (state == RESP).
- Reset state: IDLE, so req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, mon_hit=0, wait counter=0.
- RAM contents are not reset.
- Acceptance edge: req_valid & req_ready high at a rising edge.
  - req_we, req_addr and req_wdata are captured into internal registers.
  - Next state is WAIT with counter=LATENCY-1 if LATENCY>0; otherwise RESP directly.
- WAIT: the counter decrements each cycle. The edge where counter==0 moves to RESP (the commit edge).
- Latency: counting the cycle after the acceptance edge as cycle 1, rsp_valid is first high in cycle LATENCY+1.
- Error check on the captured address: err = (addr[1:0] != 0) or (addr[31:2] >= DEPTH).
- Commit edge, err=0, store: RAM[addr[31:2]] <= wdata; rsp_rdata <= 0; rsp_err <= 0.
- Commit edge, err=0, load: rsp_rdata <= RAM[addr[31:2]], sampled at this edge; rsp_err <= 0.
- Commit edge, err=1: no RAM write; rsp_rdata <= 0; rsp_err <= 1.
- A store that reads back in a later request returns the new value; there is no read-during-write within one request.
- RESP: rsp_rdata and rsp_err are held stable until the edge where rsp_ready=1, which moves to IDLE.
- rsp_valid never drops without a handshake.
- A new request can be accepted no sooner than the cycle after the response handshake. Minimum request spacing is LATENCY+2 cycles.
- req_* inputs are ignored outside IDLE; the initiator holds req_valid until accepted.
- mon_hit is set at the commit edge of an error-free store with addr==MON_ADDR and wdata==MON_DATA. It stays high until reset.
- Reset mid-operation (WAIT or RESP): FSM returns to IDLE asynchronously.
  - An uncommitted store is dropped: RAM unchanged.
  - Any pending response is discarded.
  - mon_hit clears.

Decomposition:
- Package mem_resp_pkg holds:
  - the state enum type (IDLE, WAIT, RESP);
  - the word width constant (32);
  - the byte-offset width constant (2).
- Sub-module resp_ram: DEPTH x 32 array, asynchronous read, synchronous write with enable. Instantiated once.
- The FSM, counter, capture registers and monitor live in mem_responder.

Test Plan:
- LATENCY=2: store 0xDEADBEEF to 0x10, then load 0x10 → store response rsp_err=0, rsp_rdata=0; load response rsp_rdata=0xDEADBEEF. rsp_valid first high in cycle 3 after each acceptance edge; req_ready low from acceptance through the handshake.
- Load from 0x100 (DEPTH=64) and store to 0x65 → rsp_err=1, rsp_rdata=0. A following load of word 0x64 is unchanged from its prior value.
- Backpressure: load response with rsp_ready held low 3 cycles → rsp_valid, rsp_rdata and rsp_err stable for all 4 cycles. FSM returns to IDLE after the edge where rsp_ready=1.
- Reset pulse during WAIT of a store of 0x55 to 0x20 (prior value 0x11) → req_ready=1 and rsp_valid=0 immediately. A later load of 0x20 returns 0x11.
- Store 6 to 0x64 → mon_hit stays 0. Store 7 to 0x64 → mon_hit=1 from the commit edge. A later store of 0 to 0x64 leaves mon_hit=1. Reset → mon_hit=0.
- LATENCY=0 build: load accepted at edge E → rsp_valid high in the cycle after E. Back-to-back requests with rsp_ready tied high are accepted every 2 cycles.
